// File: rtl/unit_input_queue_pkg.sv
// Shared types and defaults for the execution-unit input queue.
// The instruction id type is a stand-in for the processor-wide id type; its
// width is sized to hold the ids a small in-flight window needs.
package unit_input_queue_pkg;

    localparam int UNIT_INPUT_QUEUE_DEFAULT_DEPTH = 4;
    localparam int ID_W = 4;

    typedef logic [ID_W-1:0] id_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter that counts 0..MAX and wraps back to 0.
// MAX need not be one less than a power of two, so arbitrary queue depths work.
module wrap_counter #(
    parameter int MAX = 3,
    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] value_o
);

    logic [W-1:0] value_q;

    // Advance on inc_i, wrapping from MAX to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else if (inc_i) begin
            value_q <= (value_q == W'(MAX)) ? '0 : value_q + 1'b1;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/unit_input_queue.sv
// Input queue of a multi-cycle execution unit (div, mul, csr).
// Accepts issued ops while not full and hands them to the unit datapath in
// issue order over a valid/ack port. Outputs are gated to zero while empty.
// Optional feature: define UNIT_INPUT_QUEUE_BYPASS_EN to present an op to the
// datapath in the same cycle it is issued into an empty queue.
module unit_input_queue
    import unit_input_queue_pkg::*;
#(
    parameter int DEPTH  = UNIT_INPUT_QUEUE_DEFAULT_DEPTH,
    parameter int DATA_W = 64,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic              new_request,
    input  id_t               id,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output id_t               out_id,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ack,
    output logic [CNT_W-1:0]  occupancy
);

    // The entry layout depends on DATA_W, so it lives here rather than in the package.
    typedef struct packed {
        id_t               id;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [PTR_W-1:0]   rdPtr;
    logic [PTR_W-1:0]   wrPtr;
    logic               storedValid;
    logic               enqFire;
    logic               deqFire;
    entry_t             headEntry;

    assign storedValid = (count_q != '0);
    assign ready       = (count_q != CNT_W'(DEPTH));
    assign occupancy   = count_q;
    assign headEntry   = mem_q[rdPtr];
    assign deqFire     = storedValid & out_ack;

`ifdef UNIT_INPUT_QUEUE_BYPASS_EN
    logic bypassHit;
    logic bypassConsumed;

    // An op issued into an empty queue is shown immediately; if the datapath
    // takes it in that same cycle it never needs to be stored.
    assign bypassHit      = ~storedValid & new_request;
    assign bypassConsumed = bypassHit & out_ack;
    assign enqFire        = new_request & ready & ~bypassConsumed;
    assign out_valid      = storedValid | bypassHit;

    // Head comes from storage when anything is held, else from the issue port.
    always_comb begin
        out_id   = '0;
        out_data = '0;
        if (storedValid) begin
            out_id   = headEntry.id;
            out_data = headEntry.data;
        end else if (bypassHit) begin
            out_id   = id;
            out_data = in_data;
        end
    end
`else
    assign enqFire   = new_request & ready;
    assign out_valid = storedValid;

    // Head comes only from storage and reads as zero while empty.
    always_comb begin
        out_id   = '0;
        out_data = '0;
        if (storedValid) begin
            out_id   = headEntry.id;
            out_data = headEntry.data;
        end
    end
`endif

    // Occupancy is unchanged when an enqueue and a dequeue coincide.
    always_comb begin
        count_d = count_q;
        case ({enqFire, deqFire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Occupancy register; reset discards every held entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage is left unreset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (enqFire) begin
            mem_q[wrPtr] <= '{id: id, data: in_data};
        end
    end

    wrap_counter #(.MAX(DEPTH - 1)) uRdPtr (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (deqFire),
        .value_o (rdPtr)
    );

    wrap_counter #(.MAX(DEPTH - 1)) uWrPtr (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (enqFire),
        .value_o (wrPtr)
    );

endmodule
